pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
Output stage directly downstream of the three-voice sample mixer. Consumes the mixer's 10-bit unsigned mixed sample and drives a 1-bit PWM audio pin plus the amplifier shutdown pin. Generates the sample-rate strobe for the mixer. A mute state machine ramps gain up and down to suppress pops at enable and disable.

Parameters:
SAMPLE_W, 10, sample and PWM counter width; PWM period = 2^SAMPLE_W clk cycles (1024 → ~97.7 kHz at 100 MHz)
RAMP_PERIODS, 64, sample ticks per gain step during ramps (≥1)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
sample_in  in  SAMPLE_W  unsigned mixed sample; captured only on sample_tick
audio_en  in  1  request audio on (1) / muted (0); sampled only on sample_tick
sample_tick  out  1  one-cycle strobe, once per PWM period
pwm_out  out  1  registered PWM (or delta-sigma) audio bit
aud_sd  out  1  amplifier enable, registered; 1 when state != OFF
state  out  2  OFF=0, UP=1, RUN=2, DOWN=3

Behaviour:
- Single clock domain. Reset is synchronous and active-high. rst=1 at an edge forces: cnt=0, state=OFF, gain=0, rc=0, duty=0, pwm_out=0, aud_sd=0. This applies identically mid-ramp or mid-period.
- cnt: SAMPLE_W-bit counter, +1 every clk, wraps 2^W-1 → 0.
- sample_tick = (cnt == 2^W-1), combinational from cnt. First assertion is the 1024th cycle after reset release.
- gain: 5-bit register, range 0..16. rc: ramp counter, 0..RAMP_PERIODS-1.
- FSM updates only on edges where sample_tick=1:
  - OFF: audio_en=1 → UP; gain stays 0, rc=0.
  - UP: if audio_en=0 → DOWN (gain unchanged, rc=0). Otherwise, if rc==RAMP_PERIODS-1, then gain+1 and rc=0, else rc+1. If the new gain is 16, state becomes RUN on the same edge.
  - RUN: gain=16. audio_en=0 → DOWN, rc=0.
  - DOWN: if audio_en=1 → UP (gain unchanged, rc=0). Otherwise step gain-1 on the same rc rule. If the new gain is 0, state becomes OFF on the same edge.
- duty: SAMPLE_W-bit register, loaded on the tick edge with (sample_in × gain_next) >> 4.
  - gain_next is the gain value being written on that same edge.
  - Full product width is SAMPLE_W+5; no overflow, max = 2^W-1.
  - Takes effect for the period starting at cnt=0.
- PWM mode: pwm_out <= (state != OFF) && (cnt < duty), evaluated with pre-edge values.
  - One-cycle latency; exactly duty high cycles per period.
  - duty=0 gives a constant 0; duty=1023 gives 1023 of 1024 high.
- aud_sd <= (state_next != OFF). It rises and falls on the same edge as the state change.
- sample_in is ignored except on tick edges. Changes between ticks have no effect.
- In OFF, duty is still loaded (with gain 0, so duty=0).

Optional Feature:
AUDIO_DELTASIGMA_EN
- Defined: PWM comparison is replaced by a first-order delta-sigma modulator.
  - SAMPLE_W-bit accumulator acc (reset 0). Each clk: {c, acc} <= acc + duty.
  - pwm_out <= c && (state != OFF).
  - In OFF, acc is held at 0.
  - cnt, sample_tick, FSM and duty logic are unchanged.
- Undefined: the PWM comparator above is used and no accumulator exists.

Test Plan:
1. Reset: hold rst 3 cycles, release → pwm_out=0, aud_sd=0, state=0; sample_tick first high exactly 1023 cycles after the first post-reset edge, then every 1024 cycles. Repeat with rst asserted mid-RUN and check the same.
2. Ramp up (RAMP_PERIODS=1, sample_in=512, audio_en=1):
   - tick1: state→UP, aud_sd=1.
   - ticks 2..17: gain 1..16; state→RUN on tick17.
   - The period after gain=8 has 256 high cycles.
   - Every RUN period has 512 high cycles.
3. Extremes in RUN: sample_in=0 → 0 high cycles per period; 1023 → 1023 high, exactly 1 low; 700 → 700 high.
4. Ramp down (RAMP_PERIODS=2): audio_en=0 in RUN → DOWN on next tick; gain decrements every 2nd tick; state=OFF and aud_sd=0 on tick 33 after entry; pwm_out stays 0 thereafter.
5. Reversal and hold-off:
   - RAMP_PERIODS=1: drop audio_en when gain=10 in UP → DOWN with gain 10, then 9 on the next tick.
   - Reassert audio_en → UP with gain unchanged.
   - Toggling audio_en or sample_in between ticks → no state or duty change.
6. With AUDIO_DELTASIGMA_EN, RUN, sample_in=256 → pwm_out high exactly 1 of every 4 cycles (period-4 pattern); sample_in=0 → constant 0.

Source files
------------

// File: rtl/pwm_audio_out.sv
// PWM audio output stage with pop-suppressing gain ramp and sample-rate strobe for the mixer.
// Define AUDIO_DELTASIGMA_EN to replace the PWM comparator with a first-order delta-sigma modulator.
module pwm_audio_out #(
  parameter int SAMPLE_W     = 10,
  parameter int RAMP_PERIODS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                audio_en,
  output logic                sample_tick,
  output logic                pwm_out,
  output logic                aud_sd,
  output logic [1:0]          state
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_PERIODS - 1);

  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] duty_next;
  logic [SAMPLE_W+4:0] prod;
  logic [4:0]          gain;
  logic [4:0]          gain_next;
  logic [RC_W-1:0]     rc;
  logic [RC_W-1:0]     rc_next;
  logic [1:0]          state_next;
  logic                pwm_bit;
  logic                unused_prod;

  assign sample_tick = (cnt == {SAMPLE_W{1'b1}});

  // Gain only moves on tick edges; a ramp reversal keeps the current gain and restarts rc.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    rc_next    = rc;
    if (sample_tick) begin
      case (state)
        ST_OFF: begin
          gain_next = 5'd0;
          rc_next   = '0;
          if (audio_en) state_next = ST_UP;
        end
        ST_UP: begin
          if (!audio_en) begin
            state_next = ST_DOWN;
            rc_next    = '0;
          end else begin
            if (rc == RC_LAST) begin
              gain_next = gain + 5'd1;
              rc_next   = '0;
            end else begin
              rc_next = rc + RC_W'(1);
            end
            if (gain_next == 5'd16) state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          gain_next = 5'd16;
          if (!audio_en) begin
            state_next = ST_DOWN;
            rc_next    = '0;
          end
        end
        default: begin
          if (audio_en) begin
            state_next = ST_UP;
            rc_next    = '0;
          end else begin
            if (rc == RC_LAST) begin
              gain_next = gain - 5'd1;
              rc_next   = '0;
            end else begin
              rc_next = rc + RC_W'(1);
            end
            if (gain_next == 5'd0) state_next = ST_OFF;
          end
        end
      endcase
    end
  end

  // Gain is in 1/16 steps, so full scale (16) reproduces the sample exactly.
  assign prod        = (SAMPLE_W+5)'(sample_in) * (SAMPLE_W+5)'(gain_next);
  assign duty_next   = prod[SAMPLE_W+3:4];
  assign unused_prod = ^{prod[SAMPLE_W+4], prod[3:0]};

`ifdef AUDIO_DELTASIGMA_EN
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, duty};
  assign pwm_bit = acc_sum[SAMPLE_W] && (state != ST_OFF);

  always_ff @(posedge clk) begin
    if (rst || (state == ST_OFF)) begin
      acc <= '0;
    end else begin
      acc <= acc_sum[SAMPLE_W-1:0];
    end
  end
`else
  assign pwm_bit = (state != ST_OFF) && (cnt < duty);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      state   <= ST_OFF;
      gain    <= 5'd0;
      rc      <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
      aud_sd  <= 1'b0;
    end else begin
      cnt     <= cnt + SAMPLE_W'(1);
      state   <= state_next;
      gain    <= gain_next;
      rc      <= rc_next;
      if (sample_tick) duty <= duty_next;
      pwm_out <= pwm_bit;
      aud_sd  <= (state_next != ST_OFF);
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: two instances (ramp of 1 and 2 ticks per step) checked every cycle
// against a tick-level behavioural model, plus directed period high-count expectations.
module tb_pwm_audio_out;

  localparam int W = 10;
  localparam int PER = 1 << W;

  typedef struct {
    int p;
    int st;
    int g;
    int rc;
    int duty;
    int acc;
    bit pwm;
    bit sd;
  } mst_t;

  logic       clk = 1'b0;
  logic [W-1:0] sample_in;
  logic       rst_v [2];
  logic       en_v  [2];
  logic       tick_o[2];
  logic       pwm_o [2];
  logic       sd_o  [2];
  logic [1:0] st_o  [2];
  logic       tick_a, tick_b, pwm_a, pwm_b, sd_a, sd_b;
  logic [1:0] st_a, st_b;

  mst_t m[2];
  int   rp[2] = '{1, 2};
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_on  = 1'b0;
  bit   done_a  = 1'b0;
  bit   done_b  = 1'b0;

  always #5 clk = ~clk;

  pwm_audio_out #(.SAMPLE_W(W), .RAMP_PERIODS(1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .sample_in(sample_in), .audio_en(en_v[0]),
    .sample_tick(tick_a), .pwm_out(pwm_a), .aud_sd(sd_a), .state(st_a)
  );

  pwm_audio_out #(.SAMPLE_W(W), .RAMP_PERIODS(2)) dut_b (
    .clk(clk), .rst(rst_v[1]), .sample_in(sample_in), .audio_en(en_v[1]),
    .sample_tick(tick_b), .pwm_out(pwm_b), .aud_sd(sd_b), .state(st_b)
  );

  assign tick_o[0] = tick_a;
  assign tick_o[1] = tick_b;
  assign pwm_o[0]  = pwm_a;
  assign pwm_o[1]  = pwm_b;
  assign sd_o[0]   = sd_a;
  assign sd_o[1]   = sd_b;
  assign st_o[0]   = st_a;
  assign st_o[1]   = st_b;

  // Model: position in the PWM period, plus the gain ramp evaluated once per sample tick.
  function automatic mst_t model_next(mst_t c, bit r, bit en, int smp, int rpp);
    mst_t n;
    int   dir;
`ifdef AUDIO_DELTASIGMA_EN
    int   sum;
`endif
    n = c;
    if (r) begin
      n.p = 0; n.st = 0; n.g = 0; n.rc = 0; n.duty = 0; n.acc = 0; n.pwm = 0; n.sd = 0;
      return n;
    end
`ifdef AUDIO_DELTASIGMA_EN
    sum   = c.acc + c.duty;
    n.pwm = (c.st != 0) && (sum >= PER);
    n.acc = (c.st == 0) ? 0 : sum % PER;
`else
    n.pwm = (c.st != 0) && (c.p < c.duty);
`endif
    if (c.p == PER - 1) begin
      if (c.st == 0) begin
        n.g = 0; n.rc = 0;
        if (en) n.st = 1;
      end else if (c.st == 2) begin
        n.g = 16;
        if (!en) begin n.st = 3; n.rc = 0; end
      end else begin
        dir = (c.st == 1) ? 1 : -1;
        if (en != (c.st == 1)) begin
          n.st = en ? 1 : 3;
          n.rc = 0;
        end else begin
          if (c.rc == rpp - 1) begin n.g = c.g + dir; n.rc = 0; end
          else n.rc = c.rc + 1;
          if (dir > 0 && n.g == 16) n.st = 2;
          if (dir < 0 && n.g == 0)  n.st = 0;
        end
      end
      n.duty = (smp * n.g) / 16;
    end
    n.sd = (n.st != 0);
    n.p  = (c.p + 1) % PER;
    return n;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) m[d] = '{default: 0};
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) m[d] <= model_next(m[d], rst_v[d], en_v[d], int'(sample_in), rp[d]);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ({tick_o[d], st_o[d], sd_o[d], pwm_o[d]} !==
            {(m[d].p == PER - 1), 2'(m[d].st), m[d].sd, m[d].pwm}) begin
          n_fail++;
          $display("FAIL cycle_dut%0d @%0t: got tick=%b st=%0d sd=%b pwm=%b, expected tick=%b st=%0d sd=%b pwm=%b",
                   d, $time, tick_o[d], st_o[d], sd_o[d], pwm_o[d],
                   (m[d].p == PER - 1), m[d].st, m[d].sd, m[d].pwm);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts pwm highs over one period; entered and left just after a tick edge.
  task automatic period(input int d, output int hi, output int tpos, output logic [15:0] win);
    hi = 0; tpos = -1; win = '0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (pwm_o[d]) hi++;
      if (tick_o[d] && tpos < 0) tpos = i;
      if (i >= 100 && i < 116) win[i-100] = pwm_o[d];
    end
  endtask

  // Leaves the caller at the negedge where the first post-reset tick is high.
  task automatic reset_check(input int d);
    int n;
    rst_v[d] = 1'b1;
    @(negedge clk);
    check($sformatf("rst_state_dut%0d", d), int'(st_o[d]), 0);
    check($sformatf("rst_pwm_dut%0d", d), int'(pwm_o[d]), 0);
    check($sformatf("rst_sd_dut%0d", d), int'(sd_o[d]), 0);
    repeat (2) @(negedge clk);
    rst_v[d] = 1'b0;
    @(negedge clk);
    n = 1;
    check($sformatf("rel_state_dut%0d", d), int'(st_o[d]), 0);
    check($sformatf("rel_sd_dut%0d", d), int'(sd_o[d]), 0);
    while (!tick_o[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("first_tick_dut%0d", d), n, 1023);
  endtask

  task automatic proc_a();
    int hi, tpos, prev;
    logic [15:0] win;
    int smp_list[5] = '{0, 1023, 700, 256, 512};
    sample_in = 10'd512;
    en_v[0] = 1'b1;
    reset_check(0);
    @(negedge clk);
    check("a_tick1_state", int'(st_o[0]), 1);
    check("a_tick1_sd", int'(sd_o[0]), 1);
    for (int k = 1; k <= 17; k++) begin
      period(0, hi, tpos, win);
      check($sformatf("a_ramp_hi_g%0d", k - 1), hi, 32 * (k - 1));
      check("a_tick_spacing", tpos, 1022);
      if (k == 15) check("a_tick16_up", int'(st_o[0]), 1);
      if (k == 16) check("a_tick17_run", int'(st_o[0]), 2);
    end
    prev = 512;
    for (int j = 0; j < 5; j++) begin
      sample_in = 10'(smp_list[j]);
      period(0, hi, tpos, win);
      check($sformatf("a_run_hi_%0d", prev), hi, prev);
`ifdef AUDIO_DELTASIGMA_EN
      if (prev == 256) begin
        check("a_ds_pattern", int'(win == {4{win[3:0]}}), 1);
        check("a_ds_ones", $countones(win[3:0]), 1);
      end
`endif
      prev = smp_list[j];
    end
    // Inputs moving between ticks must not disturb state or duty.
    repeat (500) @(negedge clk);
    sample_in = 10'd100;
    en_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    sample_in = 10'd512;
    en_v[0] = 1'b1;
    repeat (PER - 510) @(negedge clk);
    check("a_hold_state", int'(st_o[0]), 2);
    period(0, hi, tpos, win);
    check("a_hold_duty", hi, 512);
    reset_check(0);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) period(0, hi, tpos, win);
    check("a_rev_up", int'(st_o[0]), 1);
    en_v[0] = 1'b0;
    period(0, hi, tpos, win);
    check("a_rev_g10_up", hi, 320);
    check("a_rev_down", int'(st_o[0]), 3);
    period(0, hi, tpos, win);
    check("a_rev_g10_down", hi, 320);
    check("a_rev_still_down", int'(st_o[0]), 3);
    en_v[0] = 1'b1;
    period(0, hi, tpos, win);
    check("a_rev_g9", hi, 288);
    check("a_rev_up_again", int'(st_o[0]), 1);
    period(0, hi, tpos, win);
    check("a_rev_g9_held", hi, 288);
    done_a = 1'b1;
  endtask

  task automatic proc_b();
    int hi, tpos;
    logic [15:0] win;
    en_v[1] = 1'b1;
    reset_check(1);
    @(negedge clk);
    check("b_tick1_state", int'(st_o[1]), 1);
    for (int i = 1; i <= 32; i++) begin
      period(1, hi, tpos, win);
      if (i == 31) check("b_tick32_up", int'(st_o[1]), 1);
      if (i == 32) check("b_tick33_run", int'(st_o[1]), 2);
    end
    period(1, hi, tpos, win);
    en_v[1] = 1'b0;
    period(1, hi, tpos, win);
    check("b_down_entry", int'(st_o[1]), 3);
    check("b_down_entry_sd", int'(sd_o[1]), 1);
    for (int i = 2; i <= 33; i++) begin
      period(1, hi, tpos, win);
      if (i == 32) check("b_down32_state", int'(st_o[1]), 3);
      if (i == 33) begin
        check("b_down33_off", int'(st_o[1]), 0);
        check("b_down33_sd", int'(sd_o[1]), 0);
      end
    end
    period(1, hi, tpos, win);
    check("b_off_hi", hi, 0);
    done_b = 1'b1;
  endtask

  initial begin
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    en_v[0]  = 1'b0; en_v[1]  = 1'b0;
    sample_in = '0;
    repeat (2) @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    fork
      begin
        fork
          proc_a();
          proc_b();
        join
      end
      begin
        #950000;
      end
    join_any
    disable fork;
    if (!(done_a && done_b)) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got done_a=%0b done_b=%0b expected 1 1", done_a, done_b);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
